// File: rtl/parity_frame_rx_pkg.sv
// Shared definitions for the parity frame receiver and its parity generator.
// State codes are plain localparams so legacy tools and older blocks can reuse them.
package parity_frame_rx_pkg;

  // Receiver state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_DATA = 2'd1;
  localparam state_t ST_PAR  = 2'd2;
  localparam state_t ST_STOP = 2'd3;

  // Frame layout: start(0), DATA_BITS data bits (first sent = a), parity, stop(1)
  localparam int   DATA_BITS = 4;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Index of the last data sample in the two-bit data counter
  localparam logic [1:0] LAST_DATA_IDX = 2'(DATA_BITS - 1);

endpackage

// File: rtl/parity_gen4.sv
// Four-bit parity generator/checker, shared with the upstream transmitter.
// x is the raw XOR of all five bits; pec flags a parity violation for the
// selected scheme (even when odd=0, odd when odd=1).
module parity_gen4 (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic p,
  input  logic odd,
  output logic x,
  output logic pec
);

  // Pure XOR reduction; odd parity simply inverts the verdict
  assign x   = a ^ b ^ c ^ d ^ p;
  assign pec = x ^ odd;

endmodule

// File: rtl/parity_frame_rx.sv
// Serial deframer feeding the 4-bit parity checker stage.
// Samples the line on bit_en strobes, rebuilds a/b/c/d/p, and presents them in
// a one-entry holding register with a valid/ready handshake. Also reports
// framing errors, overruns and keeps a saturating error count.
module parity_frame_rx
  import parity_frame_rx_pkg::*;
#(
  parameter bit ODD_PARITY = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             sin,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             p,
  output logic             pec,
  output logic             frame_err,
  output logic             overrun,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state;
  logic [1:0] cnt;
  logic [3:0] shreg;
  logic       par_bit;

  logic       stop_evt;
  logic       good_stop;
  logic       bad_stop;
  logic       load;
  logic       drop;
  logic       transfer;
  logic       pec_new;
  logic       par_x_unused;
  logic       count_err;

  // Parity verdict for the frame sitting in the shift register
  parity_gen4 u_parity (
    .a   (shreg[3]),
    .b   (shreg[2]),
    .c   (shreg[1]),
    .d   (shreg[0]),
    .p   (par_bit),
    .odd (ODD_PARITY),
    .x   (par_x_unused),
    .pec (pec_new)
  );

  // Stop-bit decisions; a good frame is dropped only when the holding
  // register is full and the consumer is not taking it this same cycle
  always_comb begin
    stop_evt  = bit_en && (state == ST_STOP);
    good_stop = stop_evt && (sin == STOP_BIT);
    bad_stop  = stop_evt && (sin != STOP_BIT);
    transfer  = out_valid && out_ready;
    load      = good_stop && (!out_valid || out_ready);
    drop      = good_stop && out_valid && !out_ready;
    count_err = (load && pec_new) || bad_stop;
  end

  // Deframing state machine; only moves on bit strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 2'd0;
      shreg   <= 4'd0;
      par_bit <= 1'b0;
    end else if (bit_en) begin
      case (state)
        ST_IDLE: begin
          if (sin == START_BIT) begin
            state <= ST_DATA;
            cnt   <= 2'd0;
          end
        end
        ST_DATA: begin
          shreg <= {shreg[2:0], sin};
          cnt   <= cnt + 2'd1;
          if (cnt == LAST_DATA_IDX) begin
            state <= ST_PAR;
          end
        end
        ST_PAR: begin
          par_bit <= sin;
          state   <= ST_STOP;
        end
        ST_STOP: begin
          // A low stop bit is a framing error, never a new start bit
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Holding register and handshake; contents are frozen while valid
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      a         <= 1'b0;
      b         <= 1'b0;
      c         <= 1'b0;
      d         <= 1'b0;
      p         <= 1'b0;
      pec       <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      a         <= shreg[3];
      b         <= shreg[2];
      c         <= shreg[1];
      d         <= shreg[0];
      p         <= par_bit;
      pec       <= pec_new;
    end else if (transfer) begin
      out_valid <= 1'b0;
    end
  end

  // Status flags: one-cycle framing pulse and a sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

  // Saturating count of parity errors on loaded frames plus framing errors
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (count_err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench for parity_frame_rx. Three instances share one stimulus
// stream: even parity/8-bit count, odd parity/8-bit count, even parity/2-bit
// count. A frame-level model predicts every output on every cycle.
module tb_parity_frame_rx;

  logic clk = 1'b0;
  logic rst;
  logic bit_en;
  logic sin;
  logic out_ready;

  logic       ov [3];
  logic       da [3];
  logic       db [3];
  logic       dc [3];
  logic       dd [3];
  logic       dp [3];
  logic       dpec [3];
  logic       fe [3];
  logic       orun [3];
  logic [7:0] cnt0;
  logic [7:0] cnt1;
  logic [1:0] cnt2;

  // Frame-level reference state per instance
  bit         m_valid [3];
  logic [4:0] m_data [3];
  bit         m_pec [3];
  bit         m_ovr [3];
  bit         m_ferr [3];
  int         m_cnt [3];
  int         maxc [3] = '{255, 255, 3};
  bit         oddp [3] = '{1'b0, 1'b1, 1'b0};

  logic [4:0] cur_frame;
  int total = 0;
  int bad   = 0;

  // Free-running clock
  always #5 clk = ~clk;

  parity_frame_rx #(.ODD_PARITY(1'b0), .CNT_W(8)) dut_even (
    .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin), .out_ready(out_ready),
    .out_valid(ov[0]), .a(da[0]), .b(db[0]), .c(dc[0]), .d(dd[0]), .p(dp[0]),
    .pec(dpec[0]), .frame_err(fe[0]), .overrun(orun[0]), .err_cnt(cnt0)
  );

  parity_frame_rx #(.ODD_PARITY(1'b1), .CNT_W(8)) dut_odd (
    .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin), .out_ready(out_ready),
    .out_valid(ov[1]), .a(da[1]), .b(db[1]), .c(dc[1]), .d(dd[1]), .p(dp[1]),
    .pec(dpec[1]), .frame_err(fe[1]), .overrun(orun[1]), .err_cnt(cnt1)
  );

  parity_frame_rx #(.ODD_PARITY(1'b0), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin), .out_ready(out_ready),
    .out_valid(ov[2]), .a(da[2]), .b(db[2]), .c(dc[2]), .d(dd[2]), .p(dp[2]),
    .pec(dpec[2]), .frame_err(fe[2]), .overrun(orun[2]), .err_cnt(cnt2)
  );

  // One comparison: counted, and reported with tag/observed/expected on failure
  task automatic compare(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  // Advance the model by one clock given this cycle's inputs
  task automatic modelStep(input logic r, input logic be, input logic s, input logic rdy, input logic is_stop);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_valid[i] = 1'b0;
        m_data[i]  = 5'd0;
        m_pec[i]   = 1'b0;
        m_ovr[i]   = 1'b0;
        m_ferr[i]  = 1'b0;
        m_cnt[i]   = 0;
      end else begin
        m_ferr[i] = 1'b0;
        if (be && is_stop && s) begin
          if (!m_valid[i] || rdy) begin
            m_valid[i] = 1'b1;
            m_data[i]  = cur_frame;
            m_pec[i]   = (^cur_frame) ^ oddp[i];
            if (m_pec[i] && m_cnt[i] < maxc[i]) m_cnt[i]++;
          end else begin
            m_ovr[i] = 1'b1;
          end
        end else begin
          if (m_valid[i] && rdy) m_valid[i] = 1'b0;
          if (be && is_stop && !s) begin
            m_ferr[i] = 1'b1;
            if (m_cnt[i] < maxc[i]) m_cnt[i]++;
          end
        end
      end
    end
  endtask

  // Compare every output of every instance against the model
  task automatic checkOutput();
    logic [7:0] c;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       c = cnt0;
        1:       c = cnt1;
        default: c = {6'd0, cnt2};
      endcase
      compare("out_valid", i, {7'd0, ov[i]}, {7'd0, m_valid[i]});
      compare("data_abcdp", i, {3'd0, da[i], db[i], dc[i], dd[i], dp[i]}, {3'd0, m_data[i]});
      compare("pec", i, {7'd0, dpec[i]}, {7'd0, m_pec[i]});
      compare("frame_err", i, {7'd0, fe[i]}, {7'd0, m_ferr[i]});
      compare("overrun", i, {7'd0, orun[i]}, {7'd0, m_ovr[i]});
      compare("err_cnt", i, c, 8'(m_cnt[i]));
    end
  endtask

  // Drive one cycle of inputs, step the model, then check after the edge
  task automatic applyStimulus(input logic r, input logic be, input logic s, input logic rdy, input logic is_stop);
    rst       = r;
    bit_en    = be;
    sin       = s;
    out_ready = rdy;
    modelStep(r, be, s, rdy, is_stop);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  // Idle line samples with the strobe active
  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b1, 1'b1, rdy, 1'b0);
  endtask

  // Consumer takes the holding register (no strobe)
  task automatic consume();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  // Send one frame {a,b,c,d,p} with chosen stop bit, random strobe gaps
  task automatic sendFrame(input logic [4:0] f, input logic stop_v, input logic rdy,
                           input logic rdy_stop, input int gapmax);
    logic [6:0] seq;
    int n;
    cur_frame = f;
    seq = {stop_v, f[0], f[1], f[2], f[3], f[4], 1'b0};
    for (int k = 0; k < 7; k++) begin
      n = $urandom_range(gapmax, 0);
      for (int g = 0; g < n; g++) applyStimulus(1'b0, 1'b0, 1'($urandom), rdy, 1'b0);
      applyStimulus(1'b0, 1'b1, seq[k], (k == 6) ? rdy_stop : rdy, k == 6);
    end
  endtask

  // Directed sequence followed by randomized frames
  initial begin
    logic [4:0] f;
    logic [3:0] dat;
    rst = 1'b1; bit_en = 1'b0; sin = 1'b1; out_ready = 1'b0; cur_frame = 5'd0;

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);

    // a=1 b=0 c=1 d=1 p=0, then same data with p=1
    sendFrame(5'b10110, 1'b1, 1'b0, 1'b0, 0);
    idle(1, 1'b0);
    consume();
    sendFrame(5'b10111, 1'b1, 1'b0, 1'b0, 0);
    consume();

    // Framing error, then a normal frame right behind it
    sendFrame(5'b10110, 1'b0, 1'b0, 1'b0, 0);
    idle(1, 1'b0);
    sendFrame(5'b01001, 1'b1, 1'b0, 1'b0, 0);
    consume();

    // Ready raised on the second frame's stop bit: replace, no overrun
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    sendFrame(5'b11000, 1'b1, 1'b0, 1'b0, 0);
    sendFrame(5'b00111, 1'b1, 1'b0, 1'b1, 0);
    consume();

    // Two frames with ready low: second dropped, overrun sticks
    sendFrame(5'b01100, 1'b1, 1'b0, 1'b0, 0);
    sendFrame(5'b10101, 1'b1, 1'b0, 1'b0, 0);
    idle(2, 1'b0);

    // Reset after start and two data bits, then a clean frame
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    sendFrame(5'b11010, 1'b1, 1'b0, 1'b0, 0);
    consume();

    // Five even-parity-error frames per run, gaps 0..5: counter saturation
    for (int g = 0; g <= 5; g++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
        dat = 4'($urandom);
        f = {dat, ~(^dat)};
        sendFrame(f, 1'b1, 1'b0, 1'b0, g);
        consume();
      end
    end

    // Randomized frames, stop bits, handshake and occasional resets
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(9, 0) == 0) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      f = 5'($urandom);
      sendFrame(f, ($urandom_range(7, 0) != 0), 1'($urandom), 1'($urandom), 3);
      idle($urandom_range(2, 0), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
